// File: rtl/ddr_cmd_sequencer_if.sv
// Request handshake plus DDR4 command/address pins and write/read timing strobes.
// master = requester side, slave = the command sequencer.
interface ddr_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_bl8;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic        cs_n;
    logic        act_n;
    logic        RAS_n_A16;
    logic        CAS_n_A15;
    logic        WE_n_A14;
    logic [1:0]  bg_addr;
    logic [1:0]  ba_addr;
    logic        A13;
    logic        A12_BC_n;
    logic        A11;
    logic        A10_AP;
    logic [9:0]  A9_A0;
    logic        rd_rdy;
    logic        wr_start;
    logic        wr_active;
    logic        busy;

    modport master (
        output req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
        input  req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
        input  bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0,
        input  rd_rdy, wr_start, wr_active, busy
    );

    modport slave (
        input  req_valid, req_wr, req_bl8, req_bg, req_ba, req_row, req_col,
        output req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
        output bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0,
        output rd_rdy, wr_start, wr_active, busy
    );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Closed-page DDR4 sequencer: one request at a time as ACT -> RD/WR -> PRE with fixed gaps.
// ACT appears the cycle after accept; req_ready is low from accept until the sequence drains.
module ddr_cmd_sequencer #(
    parameter int T_RCD = 4,
    parameter int CL    = 5,
    parameter int CWL   = 4,
    parameter int T_WR  = 4,
    parameter int T_RTP = 3,
    parameter int T_RP  = 4
) (
    input  logic               CK_t,
    input  logic               reset_n,
    ddr_cmd_sequencer_if.slave bus
);
    localparam logic [5:0] L_TRCD     = 6'(T_RCD - 1);
    localparam logic [5:0] L_TRP      = 6'(T_RP - 1);
    localparam logic [5:0] L_RD_POST  = 6'(T_RTP - 1);
    localparam logic [5:0] L_WR8_POST = 6'(CWL + 4 + T_WR - 1);
    localparam logic [5:0] L_WR4_POST = 6'(CWL + 2 + T_WR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_TRCD, S_CAS, S_POST, S_PRE, S_TRP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic        r_wr, r_bl8;
    logic [1:0]  r_bg, r_ba;
    logic [9:0]  r_col;
    logic        w_accept;

    logic        w_cs_n, w_act_n, w_ras, w_cas, w_we;
    logic [1:0]  w_bg, w_ba;
    logic        w_a13, w_a12, w_a11, w_a10;
    logic [9:0]  w_a9_0;

    logic        r_cs_n, r_act_n, r_ras, r_cas, r_we;
    logic [1:0]  r_bg_o, r_ba_o;
    logic        r_a13, r_a12, r_a11, r_a10;
    logic [9:0]  r_a9_0;
    logic        r_req_ready, r_busy;

    logic [CL-1:0]  r_rd_sh;
    logic [CWL-1:0] r_wr_sh, r_wbl_sh;
    logic [1:0]     r_wact_cnt;
    logic           r_rd_rdy, r_wr_start, r_wr_active;
    logic           w_rd_cas, w_wr_cas;

    assign w_accept = bus.req_valid && r_req_ready;

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_bl8   <= 1'b0;
            r_bg    <= '0;
            r_ba    <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wr  <= bus.req_wr;
                r_bl8 <= bus.req_bl8;
                r_bg  <= bus.req_bg;
                r_ba  <= bus.req_ba;
                r_col <= bus.req_col;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nxt = S_ACT;
                w_cnt_nxt   = '0;
            end
            S_ACT: begin
                w_state_nxt = S_TRCD;
                w_cnt_nxt   = L_TRCD;
            end
            S_TRCD: if (r_cnt <= 6'd1) w_state_nxt = S_CAS;
                    else w_cnt_nxt = r_cnt - 6'd1;
            S_CAS: begin
                w_state_nxt = S_POST;
                w_cnt_nxt   = r_wr ? (r_bl8 ? L_WR8_POST : L_WR4_POST) : L_RD_POST;
            end
            S_POST: if (r_cnt <= 6'd1) w_state_nxt = S_PRE;
                    else w_cnt_nxt = r_cnt - 6'd1;
            S_PRE: begin
                w_state_nxt = S_TRP;
                w_cnt_nxt   = L_TRP;
            end
            S_TRP: if (r_cnt <= 6'd1) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - 6'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pins are decoded from the state being entered so each command lands with its state.
    always_comb begin
        w_cs_n = 1'b1;
        w_act_n = 1'b1;
        w_ras  = 1'b1;
        w_cas  = 1'b1;
        w_we   = 1'b1;
        w_bg   = '0;
        w_ba   = '0;
        w_a13  = 1'b0;
        w_a12  = 1'b0;
        w_a11  = 1'b0;
        w_a10  = 1'b0;
        w_a9_0 = '0;
        case (w_state_nxt)
            S_ACT: begin
                w_cs_n  = 1'b0;
                w_act_n = 1'b0;
                w_bg    = bus.req_bg;
                w_ba    = bus.req_ba;
                {w_a13, w_a12, w_a11, w_a10, w_a9_0} = bus.req_row;
            end
            S_CAS: begin
                w_cs_n = 1'b0;
                w_cas  = 1'b0;
                w_we   = ~r_wr;
                w_bg   = r_bg;
                w_ba   = r_ba;
                w_a12  = r_bl8;
                w_a9_0 = r_col;
            end
            S_PRE: begin
                w_cs_n = 1'b0;
                w_ras  = 1'b0;
                w_we   = 1'b0;
                w_bg   = r_bg;
                w_ba   = r_ba;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n      <= 1'b1;
            r_act_n     <= 1'b1;
            r_ras       <= 1'b1;
            r_cas       <= 1'b1;
            r_we        <= 1'b1;
            r_bg_o      <= '0;
            r_ba_o      <= '0;
            r_a13       <= 1'b0;
            r_a12       <= 1'b1;
            r_a11       <= 1'b0;
            r_a10       <= 1'b0;
            r_a9_0      <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cs_n      <= w_cs_n;
            r_act_n     <= w_act_n;
            r_ras       <= w_ras;
            r_cas       <= w_cas;
            r_we        <= w_we;
            r_bg_o      <= w_bg;
            r_ba_o      <= w_ba;
            r_a13       <= w_a13;
            r_a12       <= w_a12;
            r_a11       <= w_a11;
            r_a10       <= w_a10;
            r_a9_0      <= w_a9_0;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Strobe pipeline is free-running so a burst in flight outlives the FSM sequence.
    assign w_rd_cas = (w_state_nxt == S_CAS) && !r_wr;
    assign w_wr_cas = (w_state_nxt == S_CAS) && r_wr;

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sh     <= '0;
            r_wr_sh     <= '0;
            r_wbl_sh    <= '0;
            r_wact_cnt  <= '0;
            r_rd_rdy    <= 1'b0;
            r_wr_start  <= 1'b0;
            r_wr_active <= 1'b0;
        end else begin
            r_rd_sh    <= (r_rd_sh << 1) | CL'(w_rd_cas);
            r_wr_sh    <= (r_wr_sh << 1) | CWL'(w_wr_cas);
            r_wbl_sh   <= (r_wbl_sh << 1) | CWL'(w_wr_cas && r_bl8);
            r_rd_rdy   <= r_rd_sh[CL-1];
            r_wr_start <= r_wr_sh[CWL-1];
            if (r_wr_sh[CWL-1]) begin
                r_wr_active <= 1'b1;
                r_wact_cnt  <= r_wbl_sh[CWL-1] ? 2'd3 : 2'd1;
            end else if (r_wact_cnt != 2'd0) begin
                r_wr_active <= 1'b1;
                r_wact_cnt  <= r_wact_cnt - 2'd1;
            end else begin
                r_wr_active <= 1'b0;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.cs_n      = r_cs_n;
    assign bus.act_n     = r_act_n;
    assign bus.RAS_n_A16 = r_ras;
    assign bus.CAS_n_A15 = r_cas;
    assign bus.WE_n_A14  = r_we;
    assign bus.bg_addr   = r_bg_o;
    assign bus.ba_addr   = r_ba_o;
    assign bus.A13       = r_a13;
    assign bus.A12_BC_n  = r_a12;
    assign bus.A11       = r_a11;
    assign bus.A10_AP    = r_a10;
    assign bus.A9_A0     = r_a9_0;
    assign bus.rd_rdy    = r_rd_rdy;
    assign bus.wr_start  = r_wr_start;
    assign bus.wr_active = r_wr_active;
endmodule
